// File: rtl/complex_fixed_mul_clocked.sv
// Three-stage pipelined signed complex multiplier: Q1.35 x Q1.35 -> Q2.35.
// Stage 1 registers operands, stage 2 forms partial products, stage 3 combines, floors and truncates.
module complex_fixed_mul_clocked #(
    parameter int NUMBER_BITS = 37,
    parameter int FRAC_BITS   = 35
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [NUMBER_BITS-1:0] x [0:1],
    input  logic signed [NUMBER_BITS-1:0] y [0:1],
    input  logic                          ready,
    output logic signed [NUMBER_BITS:0]   out [0:1],
    output logic                          available
);

    localparam int REAL  = 0;
    localparam int IMAG  = 1;
    localparam int PBITS = 2 * NUMBER_BITS;
    localparam int SBITS = PBITS + 1;

    logic signed [NUMBER_BITS-1:0] r_a;
    logic signed [NUMBER_BITS-1:0] r_b;
    logic signed [NUMBER_BITS-1:0] r_c;
    logic signed [NUMBER_BITS-1:0] r_d;
    logic                          r_valid1;

    logic signed [PBITS-1:0]       r_ac;
    logic signed [PBITS-1:0]       r_bd;
    logic signed [PBITS-1:0]       r_ad;
    logic signed [PBITS-1:0]       r_bc;
    logic                          r_valid2;

    logic signed [NUMBER_BITS:0]   r_out_re;
    logic signed [NUMBER_BITS:0]   r_out_im;
    logic                          r_available;

    logic signed [SBITS-1:0]       w_re;
    logic signed [SBITS-1:0]       w_im;

    // Stage 1: capture operands and their valid flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_d      <= '0;
            r_valid1 <= 1'b0;
        end else begin
            r_a      <= x[REAL];
            r_b      <= x[IMAG];
            r_c      <= y[REAL];
            r_d      <= y[IMAG];
            r_valid1 <= ready;
        end
    end

    // Stage 2: full-precision partial products
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ac     <= '0;
            r_bd     <= '0;
            r_ad     <= '0;
            r_bc     <= '0;
            r_valid2 <= 1'b0;
        end else begin
            r_ac     <= r_a * r_c;
            r_bd     <= r_b * r_d;
            r_ad     <= r_a * r_d;
            r_bc     <= r_b * r_c;
            r_valid2 <= r_valid1;
        end
    end

    // Combine products one bit wider so the sum/difference cannot overflow
    always_comb begin
        w_re = '0;
        w_im = '0;
        w_re = SBITS'(r_ac) - SBITS'(r_bd);
        w_im = SBITS'(r_ad) + SBITS'(r_bc);
    end

    // Stage 3: floor-scale back to Q2.35; out holds its value on idle cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_available <= 1'b0;
        end else begin
            if (r_valid2) begin
                r_out_re <= (NUMBER_BITS + 1)'(w_re >>> FRAC_BITS);
                r_out_im <= (NUMBER_BITS + 1)'(w_im >>> FRAC_BITS);
            end else begin
                r_out_re <= r_out_re;
                r_out_im <= r_out_im;
            end
            r_available <= r_valid2;
        end
    end

    assign out[REAL] = r_out_re;
    assign out[IMAG] = r_out_im;
    assign available = r_available;

endmodule

// File: tb/tb_complex_fixed_mul_clocked.sv
// Scoreboard bench for complex_fixed_mul_clocked: expected results are queued
// when operands are driven and popped when available is seen.
module tb_complex_fixed_mul_clocked;

    localparam int NB = 37;

    logic                 clk;
    logic                 reset;
    logic                 ready;
    logic signed [NB-1:0] x [0:1];
    logic signed [NB-1:0] y [0:1];
    logic signed [NB:0]   out [0:1];
    logic                 available;

    typedef struct {
        logic signed [NB:0] re;
        logic signed [NB:0] im;
        int                 tol;
    } exp_t;

    exp_t       sb [$];
    int         n_cmp;
    int         n_err;
    int         avail_cnt;
    logic [2:0] ready_pipe;

    complex_fixed_mul_clocked dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .ready     (ready),
        .out       (out),
        .available (available)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference definition: floor((a*c - b*d) / 2^35), wrapped to 38 bits
    function automatic logic signed [NB:0] model_re(input logic signed [NB-1:0] a, b, c, d);
        logic signed [74:0] aa, bb, cc, dd, t;
        aa = a; bb = b; cc = c; dd = d;
        t  = aa * cc - bb * dd;
        return (NB + 1)'(t >>> 35);
    endfunction

    function automatic logic signed [NB:0] model_im(input logic signed [NB-1:0] a, b, c, d);
        logic signed [74:0] aa, bb, cc, dd, t;
        aa = a; bb = b; cc = c; dd = d;
        t  = aa * dd + bb * cc;
        return (NB + 1)'(t >>> 35);
    endfunction

    task automatic check(input string tag, input logic signed [NB:0] obs,
                         input logic signed [NB:0] expv, input int tol);
        longint diff;
        diff = longint'(obs) - longint'(expv);
        if (diff < 0) diff = -diff;
        n_cmp++;
        assert ((tol == 0) ? (obs === expv) : (!$isunknown(obs) && diff <= longint'(tol)))
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, expv, tol);
        end
    endtask

    // Expected available: ready delayed by three edges, cleared by reset
    always @(posedge clk or negedge reset) begin
        if (!reset) ready_pipe <= 3'b000;
        else        ready_pipe <= {ready_pipe[1:0], ready};
    end

    // Monitor: check handshake each cycle and pop scoreboard on each result
    always @(negedge clk) begin
        if (reset) begin
            check("available", {37'd0, available}, {37'd0, ready_pipe[2]}, 0);
            if (available === 1'b1) begin
                avail_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_result", 38'sd1, 38'sd0, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_re", out[0], e.re, e.tol);
                    check("out_im", out[1], e.im, e.tol);
                end
            end
        end
    end

    task automatic send_exp(input logic signed [NB-1:0] a, b, c, d,
                            input logic signed [NB:0] er, ei, input int tol);
        exp_t e;
        x[0] = a; x[1] = b; y[0] = c; y[1] = d;
        ready = 1'b1;
        e.re = er; e.im = ei; e.tol = tol;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic send_model(input logic signed [NB-1:0] a, b, c, d);
        send_exp(a, b, c, d, model_re(a, b, c, d), model_im(a, b, c, d), 0);
    endtask

    task automatic idle(input int n);
        ready = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic signed [NB-1:0] rnd_op();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[NB-1:0];
    endfunction

    initial begin
        int cnt0;
        n_cmp = 0; n_err = 0; avail_cnt = 0;
        ready = 1'b0;
        x[0] = '0; x[1] = '0; y[0] = '0; y[1] = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_out_re", out[0], 38'sd0, 0);
        check("rst_out_im", out[1], 38'sd0, 0);
        check("rst_available", {37'd0, available}, 38'sd0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Directed vectors, back to back
        send_exp(37'sd13654556672, 37'sd20920401920, 37'sd25615794176, 37'sd6051463168,
                 38'sd6495197059, 38'sd18001381437, 6);
        send_exp(-37'sd18803458048, 37'sd22427992064, -37'sd988151808, 37'sd14104526848,
                 -38'sd8665826904, -38'sd8363746450, 6);
        send_exp(37'sd34359738368, 37'sd0, 37'sd25615794176, 37'sd6051463168,
                 38'sd25615794176, 38'sd6051463168, 0);
        send_exp(37'sd0, 37'sd34359738368, 37'sd0, 37'sd34359738368,
                 -38'sd34359738368, 38'sd0, 0);
        send_exp(-37'sd34359738368, 37'sd0, -37'sd34359738368, 37'sd0,
                 38'sd34359738368, 38'sd0, 0);
        idle(6);
        check("hold_re", out[0], 38'sd34359738368, 0);
        check("hold_im", out[1], 38'sd0, 0);
        check("hold_available", {37'd0, available}, 38'sd0, 0);

        // Single-cycle ready pulse gives exactly one result
        cnt0 = avail_cnt;
        send_model(rnd_op(), rnd_op(), rnd_op(), rnd_op());
        idle(6);
        check("pulse_count", 38'(avail_cnt - cnt0), 38'sd1, 0);

        // Random traffic with gaps
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) != 0) send_model(rnd_op(), rnd_op(), rnd_op(), rnd_op());
            else                           idle(1);
        end
        idle(5);

        // Reset while a result is in flight
        send_model(37'sd12345678901, -37'sd2222222222, 37'sd3333333333, 37'sd30000000000);
        ready = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        sb.delete();
        check("midrst_out_re", out[0], 38'sd0, 0);
        check("midrst_out_im", out[1], 38'sd0, 0);
        check("midrst_available", {37'd0, available}, 38'sd0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cnt0 = avail_cnt;
        idle(6);
        check("post_rst_results", 38'(avail_cnt - cnt0), 38'sd0, 0);
        check("post_rst_available", {37'd0, available}, 38'sd0, 0);

        // Accepts again after reset
        send_model(37'sd34359738368, 37'sd34359738368, 37'sd17179869184, -37'sd17179869184);
        idle(5);
        check("sb_drained", 38'(sb.size()), 38'sd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
